mm2s_ram_streamer: RTL and testbench
====================================

MM2S_RAM_STREAMER -- requirements
Module: mm2s_ram_streamer

Interface
REQ-001 SHALL have parameter AXI_WIDTH, default 128, data-word width in bits, a power of two and at least 32.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words, a power of two and at least 4.
REQ-004 SHALL derive the localparam LSB = $clog2(AXI_WIDTH)-3, with word address = byte address >> LSB.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-008 SHALL have port cmd_addr, input, AXI_ADDR_WIDTH: start byte address; bits [LSB-1:0] are ignored.
REQ-009 SHALL have port cmd_bytes, input, 32: transfer length in bytes.
REQ-010 SHALL have port mm2s_ren, input to RAM / output of block, 1: RAM read enable.
REQ-011 SHALL have port mm2s_addr, output, AXI_ADDR_WIDTH-LSB: RAM word address.
REQ-012 SHALL have port mm2s_data, input, AXI_WIDTH: RAM read data, valid in the cycle after mm2s_ren is sampled high.
REQ-013 SHALL have ports m_axis_tdata (output, AXI_WIDTH), m_axis_tkeep (output, AXI_WIDTH/8), m_axis_tlast (output, 1), m_axis_tvalid (output, 1), m_axis_tready (input, 1).
REQ-014 SHALL have port done, output, 1: single-cycle completion pulse.

Function
REQ-015 SHALL implement the states IDLE, RUN and DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-016 On a cmd handshake: latch word address = cmd_addr>>LSB; latch nwords = ceil(cmd_bytes/(AXI_WIDTH/8)); latch rem = cmd_bytes mod (AXI_WIDTH/8); go IDLE->RUN.
REQ-017 SHALL assert mm2s_ren only in RUN, and only when occupancy + outstanding < FIFO_DEPTH. Outstanding = reads issued but not yet written to the buffer. Pops in the same cycle are not credited.
REQ-018 Each mm2s_ren SHALL present the current address; the address then increments by 1 and wraps modulo 2^(AXI_ADDR_WIDTH-LSB).
REQ-019 Capture: mm2s_data SHALL be written into the buffer at the edge ending the cycle after the issuing mm2s_ren.
REQ-020 Timing: first m_axis_tvalid SHALL be exactly 3 cycles after the command-handshake cycle when the buffer is empty. Sustained throughput SHALL be 1 beat/cycle while m_axis_tready=1.
REQ-021 When the final read issues: RUN->DRAIN. When the tlast beat completes its handshake: DRAIN->IDLE, with done=1 for that following cycle only.
REQ-022 m_axis_tlast SHALL be 1 only on beat nwords.
REQ-023 m_axis_tkeep SHALL be all ones, except on the last beat when rem!=0, where it SHALL be (1<<rem)-1.
REQ-024 Once m_axis_tvalid=1, m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL hold stable until the tready handshake; beats SHALL leave in address order with no loss or duplication.
REQ-025 cmd_bytes=0: accept the command, issue no reads, emit no beats, pulse done in the cycle after the handshake, return to IDLE.
REQ-026 A cmd_valid held high during done SHALL be accepted in that cycle (cmd_ready=1), giving back-to-back commands.

Reset
REQ-027 While rstn=0, the following SHALL be 0: mm2s_ren, mm2s_addr, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, done.
REQ-028 While rstn=0, the state SHALL be IDLE, the buffer and outstanding count empty, and cmd_ready=1.
REQ-029 Reset asserted mid-transfer SHALL abort it; the in-flight RAM word SHALL be discarded and no beat emitted after release until a new command.

Verification
REQ-030 Aligned transfer: AXI_WIDTH=128, cmd_addr=0x1000, cmd_bytes=64, tready=1 -> mm2s_ren for 4 consecutive cycles at addr 0x100..0x103; 4 beats, tkeep=0xFFFF; tlast on beat 4; done one cycle after beat 4.
REQ-031 Partial last word: cmd_bytes=20 -> 2 beats; beat 2 has tkeep=0x000F and tlast=1.
REQ-032 Zero length: cmd_bytes=0 -> no mm2s_ren, no tvalid, done pulse exactly 1 cycle after the handshake.
REQ-033 Backpressure: random tready at 50%, 256 bytes -> occupancy+outstanding never exceeds 4; 16 beats matching RAM contents in order; tdata stable while stalled.
REQ-034 Reset mid-transfer: rstn=0 after beat 2 of 8 -> all outputs 0 on the next cycle; after release cmd_ready=1 and no stray beats.
REQ-035 Address wrap: cmd_addr=0xFFFFFFF0, cmd_bytes=32 -> addr 0x0FFFFFFF then 0x00000000.

Source files
------------

// File: rtl/mm2s_ram_streamer.sv
// rtl/mm2s_ram_streamer.sv - RAM-to-stream reader with credit-limited prefetch buffer
module mm2s_ram_streamer #(
    parameter int  AXI_WIDTH      = 128,
    parameter int  AXI_ADDR_WIDTH = 32,
    parameter int  FIFO_DEPTH     = 4,
    localparam int LSB            = $clog2(AXI_WIDTH) - 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [31:0]                   cmd_bytes,
    output logic                          mm2s_ren,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] mm2s_addr,
    input  logic [AXI_WIDTH-1:0]          mm2s_data,
    output logic [AXI_WIDTH-1:0]          m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0]        m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          done
);
    localparam int KW = AXI_WIDTH / 8;
    localparam int AW = AXI_ADDR_WIDTH - LSB;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state, state_next;
    logic [AW-1:0]        addr;
    logic [31:0]          reads_left;
    logic [31:0]          nwords;
    logic [31:0]          beat_cnt;
    logic [LSB-1:0]       rem;
    logic                 pending;
    logic [CW-1:0]        count;
    logic [CW-1:0]        credit;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [AXI_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [KW-1:0]        part_keep;
    logic [LSB-1:0]       cmd_rem;
    logic [31:0]          cmd_nwords;
    logic                 cmd_fire;
    logic                 pop;
    logic                 done_set;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr[LSB-1:0];
    assign cmd_rem         = cmd_bytes[LSB-1:0];
    assign cmd_nwords      = (cmd_bytes >> LSB) + 32'(|cmd_rem);
    assign cmd_fire        = cmd_valid && cmd_ready;
    assign pop             = m_axis_tvalid && m_axis_tready;
    // A read in flight has a reserved slot; a pop this cycle frees nothing yet.
    assign credit          = count + CW'(pending);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        mm2s_ren   = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_nwords == 32'd0) begin
                        done_set = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                mm2s_ren = (credit < CW'(FIFO_DEPTH));
                if (mm2s_ren && reads_left == 32'd1) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr       <= '0;
            reads_left <= '0;
            nwords     <= '0;
            rem        <= '0;
            beat_cnt   <= '0;
            pending    <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            done       <= 1'b0;
        end else begin
            done    <= done_set;
            pending <= mm2s_ren;
            count   <= count + CW'(pending) - CW'(pop);
            if (cmd_fire) begin
                addr       <= cmd_addr[AXI_ADDR_WIDTH-1:LSB];
                reads_left <= cmd_nwords;
                nwords     <= cmd_nwords;
                rem        <= cmd_rem;
            end else if (mm2s_ren) begin
                addr       <= addr + AW'(1);
                reads_left <= reads_left - 32'd1;
            end
            if (pending) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (cmd_fire) begin
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Buffer storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (pending) begin
            mem[wr_ptr] <= mm2s_data;
        end
    end

    always_comb begin
        part_keep = '0;
        for (int i = 0; i < KW; i++) begin
            part_keep[i] = (i < int'(rem));
        end
    end

    assign mm2s_addr     = addr;
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == nwords - 32'd1);
    assign m_axis_tkeep  = !m_axis_tvalid ? '0 :
                           (m_axis_tlast && rem != '0) ? part_keep : '1;
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mm2s_ram_streamer.sv
// tb/tb_mm2s_ram_streamer.sv - scoreboard bench for mm2s_ram_streamer
module tb_mm2s_ram_streamer;
    localparam int AXI_WIDTH      = 128;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int FIFO_DEPTH     = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_addr = '0;
    logic [31:0]   cmd_bytes = '0;
    logic          mm2s_ren;
    logic [27:0]   mm2s_addr;
    logic [127:0]  mm2s_data = '0;
    logic [127:0]  m_axis_tdata;
    logic [15:0]   m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          done;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int bp = 0;

    logic [27:0]  exp_addr_q[$];
    logic [127:0] exp_data_q[$];
    logic [15:0]  exp_keep_q[$];
    logic         exp_last_q[$];

    int issued = 0, popped = 0;
    int ren_count, beat_count, first_ren, last_ren, first_valid, last_beat_cyc, done_cyc;
    logic         held_valid = 1'b0;
    logic [127:0] held_data;
    logic [15:0]  held_keep;
    logic         held_last;

    mm2s_ram_streamer #(
        .AXI_WIDTH(AXI_WIDTH),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_bytes(cmd_bytes),
        .mm2s_ren(mm2s_ren),
        .mm2s_addr(mm2s_addr),
        .mm2s_data(mm2s_data),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ram_word(input logic [27:0] a);
        logic [31:0] a32;
        a32 = {4'h0, a};
        return {4'hC, a, 4'h3, ~a, a32 ^ 32'h1234_5678, a32 * 32'd2654435761};
    endfunction

    // RAM model: one-cycle read latency
    always begin
        logic        s_ren;
        logic [27:0] s_addr;
        @(negedge clk);
        s_ren  = mm2s_ren;
        s_addr = mm2s_addr;
        @(posedge clk);
        #1;
        mm2s_data = s_ren ? ram_word(s_addr) : {4{32'hDEADBEEF}};
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rstn) begin
            issued     = 0;
            popped     = 0;
            held_valid = 1'b0;
        end else begin
            if (mm2s_ren) begin
                issued++;
                ren_count++;
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
                if (exp_addr_q.size() == 0) check("ren_extra", 128'(mm2s_addr), 128'hFFFF_FFFF);
                else check("ren_addr", 128'(mm2s_addr), 128'(exp_addr_q.pop_front()));
                check("credit_limit", 128'((issued - popped) <= FIFO_DEPTH), 128'd1);
            end
            if (held_valid) begin
                check("stall_valid", 128'(m_axis_tvalid), 128'd1);
                check("stall_data", m_axis_tdata, held_data);
                check("stall_keep", 128'(m_axis_tkeep), 128'(held_keep));
                check("stall_last", 128'(m_axis_tlast), 128'(held_last));
            end
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                popped++;
                beat_count++;
                if (exp_data_q.size() == 0) begin
                    check("beat_extra", 128'd1, 128'd0);
                end else begin
                    check("beat_data", m_axis_tdata, exp_data_q.pop_front());
                    check("beat_keep", 128'(m_axis_tkeep), 128'(exp_keep_q.pop_front()));
                    check("beat_last", 128'(m_axis_tlast), 128'(exp_last_q.pop_front()));
                end
                if (m_axis_tlast) last_beat_cyc = cyc;
            end
            held_valid = m_axis_tvalid && !m_axis_tready;
            held_data  = m_axis_tdata;
            held_keep  = m_axis_tkeep;
            held_last  = m_axis_tlast;
            if (done) done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        ren_count     = 0;
        beat_count    = 0;
        first_ren     = -1;
        last_ren      = -1;
        first_valid   = -1;
        last_beat_cyc = -1;
        done_cyc      = -1;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] bytes, output int hs);
        int          nw;
        int          r;
        logic [27:0] wa;
        logic [16:0] one;
        one = 17'd1;
        wa  = addr[31:4];
        nw  = int'((bytes + 32'd15) >> 4);
        r   = int'(bytes % 32'd16);
        for (int i = 0; i < nw; i++) begin
            exp_addr_q.push_back(wa + 28'(i));
            exp_data_q.push_back(ram_word(wa + 28'(i)));
            exp_keep_q.push_back((i == nw - 1 && r != 0) ? 16'((one << r) - 17'd1) : 16'hFFFF);
            exp_last_q.push_back(i == nw - 1);
        end
        cmd_addr  = addr;
        cmd_bytes = bytes;
        cmd_valid = 1'b1;
        hs = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) check("cmd_timeout", 128'd0, 128'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int seen;
        seen = 0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) check("done_timeout", 128'd0, 128'd1);
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ren"}, 128'(mm2s_ren), 128'd0);
        check({tag, "_addr"}, 128'(mm2s_addr), 128'd0);
        check({tag, "_tvalid"}, 128'(m_axis_tvalid), 128'd0);
        check({tag, "_tlast"}, 128'(m_axis_tlast), 128'd0);
        check({tag, "_tkeep"}, 128'(m_axis_tkeep), 128'd0);
        check({tag, "_tdata"}, m_axis_tdata, 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
        check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'd1);
    endtask

    initial begin
        int hs, hs_b;
        clear_stats();
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        tick();
        rstn = 1'b1;
        tick();

        // aligned 64 bytes
        clear_stats();
        send_cmd(32'h0000_1000, 32'd64, hs);
        wait_done(100);
        check("al_first_valid", 128'(first_valid - hs), 128'd3);
        check("al_ren_count", 128'(ren_count), 128'd4);
        check("al_ren_span", 128'(last_ren - first_ren), 128'd3);
        check("al_beats", 128'(beat_count), 128'd4);
        check("al_done_cyc", 128'(done_cyc), 128'(last_beat_cyc + 1));
        @(negedge clk);
        check("al_done_pulse", 128'(done), 128'd0);
        check("al_sb_empty", 128'(exp_data_q.size()), 128'd0);
        tick();

        // partial last word
        clear_stats();
        send_cmd(32'h0000_2000, 32'd20, hs);
        wait_done(100);
        check("part_beats", 128'(beat_count), 128'd2);
        check("part_sb_empty", 128'(exp_data_q.size()), 128'd0);

        // zero length
        clear_stats();
        send_cmd(32'h0000_4000, 32'd0, hs);
        wait_done(20);
        check("zero_done_cyc", 128'(done_cyc), 128'(hs + 1));
        check("zero_ren", 128'(ren_count), 128'd0);
        check("zero_valid", 128'(first_valid), 128'(-1));

        // address wrap
        clear_stats();
        send_cmd(32'hFFFF_FFF0, 32'd32, hs);
        wait_done(100);
        check("wrap_beats", 128'(beat_count), 128'd2);
        check("wrap_addr_q_empty", 128'(exp_addr_q.size()), 128'd0);

        // random backpressure
        clear_stats();
        bp = 1;
        send_cmd(32'h0000_3000, 32'd256, hs);
        wait_done(2000);
        bp = 0;
        check("bp_beats", 128'(beat_count), 128'd16);
        check("bp_sb_empty", 128'(exp_data_q.size()), 128'd0);
        tick();

        // back-to-back: second command accepted in the done cycle
        clear_stats();
        send_cmd(32'h0000_6000, 32'd48, hs);
        send_cmd(32'h0000_7000, 32'd36, hs_b);
        check("b2b_hs_in_done", 128'(hs_b), 128'(done_cyc));
        wait_done(100);
        check("b2b_sb_empty", 128'(exp_data_q.size()), 128'd0);

        // reset in the middle of an 8-beat transfer
        clear_stats();
        send_cmd(32'h0000_5000, 32'd128, hs);
        begin
            int reached;
            reached = 0;
            for (int n = 0; n < 200; n++) begin
                @(posedge clk);
                if (beat_count >= 2) begin
                    reached = 1;
                    break;
                end
            end
            if (reached == 0) check("mid_rst_timeout", 128'd0, 128'd1);
        end
        #1;
        rstn = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_keep_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        check_outputs_zero("mid_rst");
        tick();
        rstn = 1'b1;
        clear_stats();
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_beats", 128'(beat_count), 128'd0);
        check("post_rst_ren", 128'(ren_count), 128'd0);
        check("post_rst_cmd_ready", 128'(cmd_ready), 128'd1);

        // streamer still works after the abort
        clear_stats();
        send_cmd(32'h0000_8000, 32'd40, hs);
        wait_done(100);
        check("after_beats", 128'(beat_count), 128'd3);
        check("after_sb_empty", 128'(exp_data_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
